id_hazard_scoreboard: RTL and testbench

//  Parametrised operand-hazard unit for the ID stage. It resolves each source operand to one of

---
 rtl/id_hazard_scoreboard.sv | 119 +++++++++++
 tb/tb_id_hazard_scoreboard.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard.sv
// ID-stage operand hazard unit: forwarding select, pending-write scoreboard, stall generation.
// Operand/stall are combinational (0 cycles); counters, stall_cycles and sb_err update at posedge.
module id_hazard_scoreboard #(
   parameter int NREG  = 32,
   parameter int AW    = 5,
   parameter int DW    = 32,
   parameter int NRD   = 2,
   parameter int NFWD  = 3,
   parameter int CNT_W = 2
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                flush,
   input  logic [NRD-1:0]      rd_need,
   input  logic [NRD*AW-1:0]   rd_addr,
   input  logic [NRD*DW-1:0]   rf_rdata,
   input  logic [NFWD-1:0]     fwd_valid,
   input  logic [NFWD-1:0]     fwd_we,
   input  logic [NFWD*AW-1:0]  fwd_addr,
   input  logic [NFWD-1:0]     fwd_ready,
   input  logic [NFWD*DW-1:0]  fwd_data,
   input  logic                id_we,
   input  logic [AW-1:0]       id_waddr,
   input  logic                issue_fire,
   input  logic                retire_fire,
   input  logic [AW-1:0]       retire_waddr,
   output logic [NRD*DW-1:0]   opnd_data,
   output logic                stall,
   output logic [NREG-1:0]     busy_vec,
   output logic [31:0]         stall_cycles,
   output logic                sb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] r_cnt [NREG];
   logic [31:0]      r_stall_cycles;
   logic             r_sb_err;

   logic             w_stall;
   logic [NREG-1:0]  w_inc;
   logic [NREG-1:0]  w_dec;
   logic             w_err;

   // Youngest matching forwarding stage wins; the scoreboard only matters when no stage matches.
   always_comb begin
      logic [AW-1:0] w_a;
      logic          w_hit;
      w_a       = '0;
      w_hit     = 1'b0;
      w_stall   = 1'b0;
      opnd_data = '0;
      for (int p = 0; p < NRD; p++) begin
         w_a   = rd_addr[p*AW +: AW];
         w_hit = 1'b0;
         if (w_a == '0) begin
            opnd_data[p*DW +: DW] = '0;
         end else if (!rd_need[p]) begin
            opnd_data[p*DW +: DW] = rf_rdata[p*DW +: DW];
         end else begin
            for (int s = 0; s < NFWD; s++) begin
               if (!w_hit && fwd_valid[s] && fwd_we[s] && fwd_addr[s*AW +: AW] == w_a) begin
                  w_hit = 1'b1;
                  if (fwd_ready[s]) opnd_data[p*DW +: DW] = fwd_data[s*DW +: DW];
                  else              w_stall = 1'b1;
               end
            end
            if (!w_hit) begin
               if (r_cnt[w_a] != '0) w_stall = 1'b1;
               else                  opnd_data[p*DW +: DW] = rf_rdata[p*DW +: DW];
            end
         end
      end
      if (id_we && id_waddr != '0 && r_cnt[id_waddr] == CNT_MAX) w_stall = 1'b1;
   end

   always_comb begin
      w_inc = '0;
      w_dec = '0;
      w_err = 1'b0;
      for (int r = 1; r < NREG; r++) begin
         w_inc[r] = issue_fire && id_we && (id_waddr == AW'(r));
         w_dec[r] = retire_fire && (retire_waddr == AW'(r));
         if (w_dec[r] && !w_inc[r] && r_cnt[r] == '0)     w_err = 1'b1;
         if (w_inc[r] && !w_dec[r] && r_cnt[r] == CNT_MAX) w_err = 1'b1;
      end
      if (flush) w_err = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
         r_stall_cycles <= '0;
         r_sb_err       <= 1'b0;
      end else begin
         if (w_stall && r_stall_cycles != 32'hFFFF_FFFF)
            r_stall_cycles <= r_stall_cycles + 32'd1;
         if (w_err)
            r_sb_err <= 1'b1;
         for (int r = 0; r < NREG; r++) begin
            if (flush)
               r_cnt[r] <= '0;
            else if (w_inc[r] && !w_dec[r] && r_cnt[r] != CNT_MAX)
               r_cnt[r] <= r_cnt[r] + 1'b1;
            else if (w_dec[r] && !w_inc[r] && r_cnt[r] != '0)
               r_cnt[r] <= r_cnt[r] - 1'b1;
         end
      end
   end

   always_comb begin
      for (int r = 0; r < NREG; r++) busy_vec[r] = (r_cnt[r] != '0);
   end

   assign stall        = w_stall;
   assign stall_cycles = r_stall_cycles;
   assign sb_err       = r_sb_err;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Randomized plus directed bench for id_hazard_scoreboard with a queue-based scoreboard.
module tb_id_hazard_scoreboard;

   localparam int NREG = 32, AW = 5, DW = 32, NRD = 2, NFWD = 3, CNT_W = 2;
   localparam int CMAX = (1 << CNT_W) - 1;

   logic                        clk, resetn, flush;
   logic [NRD-1:0]              rd_need;
   logic [NRD-1:0][AW-1:0]      rd_addr;
   logic [NRD-1:0][DW-1:0]      rf_rdata;
   logic [NFWD-1:0]             fwd_valid, fwd_we, fwd_ready;
   logic [NFWD-1:0][AW-1:0]     fwd_addr;
   logic [NFWD-1:0][DW-1:0]     fwd_data;
   logic                        id_we, issue_fire, retire_fire;
   logic [AW-1:0]               id_waddr, retire_waddr;
   logic [NRD-1:0][DW-1:0]      opnd_data;
   logic                        stall, sb_err;
   logic [NREG-1:0]             busy_vec;
   logic [31:0]                 stall_cycles;

   id_hazard_scoreboard #(.NREG(NREG), .AW(AW), .DW(DW), .NRD(NRD), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .rd_need(rd_need), .rd_addr(rd_addr), .rf_rdata(rf_rdata),
      .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_addr(fwd_addr),
      .fwd_ready(fwd_ready), .fwd_data(fwd_data),
      .id_we(id_we), .id_waddr(id_waddr), .issue_fire(issue_fire),
      .retire_fire(retire_fire), .retire_waddr(retire_waddr),
      .opnd_data(opnd_data), .stall(stall), .busy_vec(busy_vec),
      .stall_cycles(stall_cycles), .sb_err(sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic                   st;
      logic [NRD-1:0]         chk;
      logic [NRD-1:0][DW-1:0] od;
      logic [NREG-1:0]        busy;
      logic [31:0]            scyc;
      logic                   err;
      int                     tag;
   } exp_t;

   exp_t        q[$];
   int          cnt_m[NREG];
   int unsigned scyc_m;
   bit          err_m;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string nm, input int tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (step %0d): got %0h expected %0h", nm, tag, act, exp);
      end
   endtask

   // Reference: per port, youngest matching stage decides, else pending count, else regfile.
   function automatic void eval(output logic st, output logic [NRD-1:0] chk,
                                output logic [NRD-1:0][DW-1:0] od);
      st = 1'b0; chk = '0; od = '0;
      for (int p = 0; p < NRD; p++) begin
         int hit;
         hit = -1;
         if (rd_addr[p] == 0) begin
            od[p] = '0; chk[p] = 1'b1;
         end else if (!rd_need[p]) begin
            od[p] = rf_rdata[p]; chk[p] = 1'b1;
         end else begin
            for (int s = 0; s < NFWD; s++)
               if (hit < 0 && fwd_valid[s] && fwd_we[s] && fwd_addr[s] == rd_addr[p]) hit = s;
            if (hit >= 0) begin
               if (fwd_ready[hit]) begin od[p] = fwd_data[hit]; chk[p] = 1'b1; end
               else st = 1'b1;
            end else if (cnt_m[rd_addr[p]] != 0) begin
               st = 1'b1;
            end else begin
               od[p] = rf_rdata[p]; chk[p] = 1'b1;
            end
         end
      end
      if (id_we && id_waddr != 0 && cnt_m[id_waddr] == CMAX) st = 1'b1;
   endfunction

   task automatic model_edge();
      logic st; logic [NRD-1:0] c; logic [NRD-1:0][DW-1:0] od;
      eval(st, c, od);
      if (!resetn) begin
         for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
         scyc_m = 0; err_m = 1'b0;
      end else begin
         if (st && scyc_m != 32'hFFFF_FFFF) scyc_m++;
         if (flush) begin
            for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
         end else begin
            for (int r = 1; r < NREG; r++) begin
               bit inc, dec;
               inc = issue_fire && id_we && id_waddr == r;
               dec = retire_fire && retire_waddr == r;
               if (inc && !dec) begin
                  if (cnt_m[r] == CMAX) err_m = 1'b1; else cnt_m[r]++;
               end else if (dec && !inc) begin
                  if (cnt_m[r] == 0) err_m = 1'b1; else cnt_m[r]--;
               end
            end
         end
      end
   endtask

   task automatic push(input int tag);
      exp_t e;
      eval(e.st, e.chk, e.od);
      for (int r = 0; r < NREG; r++) e.busy[r] = (cnt_m[r] != 0);
      e.scyc = scyc_m; e.err = err_m; e.tag = tag;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic clr();
      flush = 0; rd_need = '0; rd_addr = '0; rf_rdata = '0;
      fwd_valid = '0; fwd_we = '0; fwd_ready = '0; fwd_addr = '0; fwd_data = '0;
      id_we = 0; id_waddr = '0; issue_fire = 0; retire_fire = 0; retire_waddr = '0;
   endtask

   // Monitor: outputs are combinational, so every cycle presents one result to compare.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("stall", e.tag, 64'(stall), 64'(e.st));
            for (int p = 0; p < NRD; p++)
               if (e.chk[p]) check("opnd_data", e.tag, 64'(opnd_data[p]), 64'(e.od[p]));
            check("busy_vec", e.tag, 64'(busy_vec), 64'(e.busy));
            check("stall_cycles", e.tag, 64'(stall_cycles), 64'(e.scyc));
            check("sb_err", e.tag, 64'(sb_err), 64'(e.err));
         end
      end
   end

   initial begin
      logic st; logic [NRD-1:0] c; logic [NRD-1:0][DW-1:0] od;
      clr();
      resetn = 0;
      for (int r = 0; r < NREG; r++) cnt_m[r] = 0;
      scyc_m = 0; err_m = 0;
      tick(); tick(); push(0);
      tick(); resetn = 1; push(1);

      // Random phase: retires only target pending registers and issue honours stall, so sb_err stays 0.
      for (int i = 0; i < 400; i++) begin
         tick(); clr();
         for (int s = 0; s < NFWD; s++) begin
            fwd_valid[s] = 1'($urandom_range(0, 1));
            fwd_we[s]    = 1'($urandom_range(0, 1));
            fwd_addr[s]  = AW'($urandom_range(0, 7));
            fwd_ready[s] = ($urandom_range(0, 3) != 0);
            fwd_data[s]  = $urandom;
         end
         for (int p = 0; p < NRD; p++) begin
            rd_need[p]  = 1'($urandom_range(0, 1));
            rd_addr[p]  = AW'($urandom_range(0, 7));
            rf_rdata[p] = $urandom;
         end
         id_we    = 1'($urandom_range(0, 1));
         id_waddr = AW'($urandom_range(0, 7));
         flush    = ($urandom_range(0, 19) == 0);
         if (!flush) begin
            int r;
            r = $urandom_range(1, 7);
            if (cnt_m[r] > 0 && $urandom_range(0, 1) == 1) begin
               retire_fire = 1; retire_waddr = AW'(r);
            end
         end
         eval(st, c, od);
         issue_fire = !flush && !st && ($urandom_range(0, 1) == 1);
         push(1000 + i);
      end

      tick(); clr(); flush = 1; push(99);

      // Youngest stage wins over an older matching stage.
      tick(); clr();
      fwd_valid = 3'b011; fwd_we = 3'b011; fwd_ready = 3'b011;
      fwd_addr[0] = 5; fwd_addr[1] = 5;
      fwd_data[0] = 32'hA0A0_0005; fwd_data[1] = 32'hB0B0_0005;
      rd_need = 2'b01; rd_addr[0] = 5; rf_rdata[0] = 32'h1111;
      push(101);

      // Load in EXE not ready, then ready.
      tick(); clr();
      fwd_valid = 3'b001; fwd_we = 3'b001; fwd_addr[0] = 7; fwd_data[0] = 32'h7777_7777;
      rd_need = 2'b10; rd_addr[1] = 7; rf_rdata[1] = 32'h2222;
      push(102);
      tick(); fwd_ready[0] = 1; push(103);

      // Long-latency writer outside the forwarding window.
      tick(); clr(); id_we = 1; id_waddr = 9; issue_fire = 1; push(104);
      tick(); clr(); rd_need = 2'b01; rd_addr[0] = 9; rf_rdata[0] = 32'h9999; push(105);
      tick(); push(106);
      tick(); retire_fire = 1; retire_waddr = 9; push(107);
      tick(); retire_fire = 0; push(108);

      // Same-cycle issue and retire, then retire underflow.
      tick(); clr(); id_we = 1; id_waddr = 3; issue_fire = 1; push(110);
      tick(); retire_fire = 1; retire_waddr = 3; push(111);
      tick(); clr(); push(112);
      tick(); retire_fire = 1; retire_waddr = 3; push(113);
      tick(); push(114);
      tick(); clr(); push(115);

      // Counter saturation guard, then flush.
      tick(); clr(); id_we = 1; id_waddr = 4; issue_fire = 1; push(120);
      tick(); push(121);
      tick(); push(122);
      tick(); issue_fire = 0; push(123);
      tick(); flush = 1; push(124);
      tick(); flush = 0; push(125);

      // Reset in the middle of activity.
      tick(); clr(); id_we = 1; id_waddr = 8; issue_fire = 1; push(130);
      tick(); resetn = 0; flush = 1; push(131);
      tick(); resetn = 1; clr(); push(132);

      // r0 reads ignore forwarding stages writing r0.
      tick(); clr();
      fwd_valid = '1; fwd_we = '1; fwd_ready = '1;
      for (int s = 0; s < NFWD; s++) fwd_data[s] = 32'hDEAD;
      rd_need = 2'b11; rf_rdata[0] = 32'h5555; rf_rdata[1] = 32'h6666;
      push(140);

      for (int i = 0; i < 10; i++) begin
         tick(); clr();
         fwd_valid = 3'b100; fwd_we = 3'b100; fwd_addr[2] = 12;
         rd_need = 2'b01; rd_addr[0] = 12;
         push(150 + i);
      end
      tick(); clr(); push(160);
      @(negedge clk); #1;
      check("stall_cycles_after_10", 170, 64'(stall_cycles), 64'd10);
      check("sb_err_after_reset", 171, 64'(sb_err), 64'd0);

      tick(); clr();
      repeat (2) @(negedge clk);
      check("queue_drained", 172, 64'(q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
